// File: rtl/hwpe_ctrl_offload_master_if.sv
// HWPE peripheral request/response port: the initiator side drives req/add/wen/be/data/id,
// and the target side returns gnt plus the r_valid/r_data read response.
interface hwpe_ctrl_offload_master_if #(
  parameter int unsigned ID_WIDTH = 16
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic                r_valid;
  logic [31:0]         r_data;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_valid, r_data
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_valid, r_data
  );
endinterface

// File: rtl/hwpe_ctrl_offload_master.sv
// Offloads one HWPE job: ACQUIRE (retry on busy), job-register writes, TRIGGER, completion wait.
// Latency: first request the cycle after job accept; all periph outputs are state-decoded and held until gnt.
// Backpressure: job_ready_o only in IDLE; periph stalls via gnt. HWPE_OFFLOAD_POLL_EN: poll STATUS instead of evt_i.
module hwpe_ctrl_offload_master #(
  parameter int unsigned N_IO_REGS   = 2,
  parameter int unsigned ID_WIDTH    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter logic [31:0] IO_OFFS     = 32'h40,
  parameter int unsigned RETRY_DELAY = 4,
  parameter int unsigned MAX_RETRY   = 0,
  parameter int unsigned MASTER_ID   = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [32*N_IO_REGS-1:0] job_data_i,
  input  logic                   evt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [7:0]             job_id_o,
  output logic                   err_o,
  hwpe_ctrl_offload_master_if.master periph
);

  localparam int unsigned KW  = $clog2(N_IO_REGS + 1);
  localparam int unsigned IW  = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;
  localparam int unsigned RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned DW  = $clog2(RETRY_DELAY + 1);
  localparam logic [ID_WIDTH-1:0] MID = ID_WIDTH'(MASTER_ID);

  typedef enum logic [3:0] {
    IDLE, ACQ, ACQ_RSP, BACKOFF, WRITE, TRIG, WAIT_CPL, POLL_RSP, POLL_DLY, DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [KW-1:0]                  k_q, k_d;
  logic [RCW-1:0]                 rcnt_q, rcnt_d;
  logic [DW-1:0]                  dly_q, dly_d;
  logic [7:0]                     job_id_q, job_id_d;
  logic [N_IO_REGS-1:0][31:0]     job_q, job_d;
  logic                           err_q, err_d;
  logic                           req;
  logic                           wen;
  logic [31:0]                    add;
  logic [31:0]                    wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      k_q      <= '0;
      rcnt_q   <= '0;
      dly_q    <= '0;
      job_id_q <= 8'h00;
      job_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      rcnt_q   <= rcnt_d;
      dly_q    <= dly_d;
      job_id_q <= job_id_d;
      job_q    <= job_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    rcnt_d   = rcnt_q;
    dly_d    = dly_q;
    job_id_d = job_id_q;
    job_d    = job_q;
    err_d    = 1'b0;
    req      = 1'b0;
    wen      = 1'b1;
    add      = BASE_ADDR;
    wdata    = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (job_valid_i) begin
          job_d   = job_data_i;
          state_d = ACQ;
        end
      end
      ACQ: begin
        req = 1'b1;
        add = BASE_ADDR + 32'h04;
        if (periph.gnt) state_d = ACQ_RSP;
      end
      ACQ_RSP: begin
        if (periph.r_valid) begin
          // FFFFFFFE: another PE is offloading; FFFFFFFF: no free context
          if (periph.r_data == 32'hFFFF_FFFE || periph.r_data == 32'hFFFF_FFFF) begin
            rcnt_d = rcnt_q + RCW'(1);
            if (MAX_RETRY != 0 && rcnt_d == RCW'(MAX_RETRY)) begin
              err_d   = 1'b1;
              rcnt_d  = '0;
              state_d = IDLE;
            end else begin
              dly_d   = '0;
              state_d = BACKOFF;
            end
          end else begin
            job_id_d = periph.r_data[7:0];
            k_d      = '0;
            state_d  = WRITE;
          end
        end
      end
      BACKOFF: begin
        if (dly_q == DW'(RETRY_DELAY - 1)) state_d = ACQ;
        else                               dly_d   = dly_q + DW'(1);
      end
      WRITE: begin
        req   = 1'b1;
        wen   = 1'b0;
        add   = BASE_ADDR + IO_OFFS + (32'(k_q) << 2);
        wdata = job_q[k_q[IW-1:0]];
        if (periph.gnt) begin
          if (k_q == KW'(N_IO_REGS - 1)) state_d = TRIG;
          else                           k_d     = k_q + KW'(1);
        end
      end
      TRIG: begin
        req = 1'b1;
        wen = 1'b0;
        if (periph.gnt) state_d = WAIT_CPL;
      end
`ifdef HWPE_OFFLOAD_POLL_EN
      WAIT_CPL: begin
        req = 1'b1;
        add = BASE_ADDR + 32'h0C;
        if (periph.gnt) state_d = POLL_RSP;
      end
      POLL_RSP: begin
        if (periph.r_valid) begin
          if (periph.r_data == 32'h0) begin
            state_d = DONE;
          end else begin
            dly_d   = '0;
            state_d = POLL_DLY;
          end
        end
      end
      POLL_DLY: begin
        if (dly_q == DW'(RETRY_DELAY - 1)) state_d = WAIT_CPL;
        else                               dly_d   = dly_q + DW'(1);
      end
`else
      WAIT_CPL: begin
        if (evt_i) state_d = DONE;
      end
`endif
      DONE: begin
        rcnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Soft clear beats every transition, including an ungranted request
    if (clear_i) begin
      state_d  = IDLE;
      k_d      = '0;
      rcnt_d   = '0;
      dly_d    = '0;
      job_id_d = 8'h00;
      job_d    = '0;
      err_d    = 1'b0;
    end
  end

`ifdef HWPE_OFFLOAD_POLL_EN
  logic unused_evt;
  assign unused_evt = evt_i;
`endif

  assign periph.req  = req;
  assign periph.add  = add;
  assign periph.wen  = wen;
  assign periph.be   = 4'hF;
  assign periph.data = wdata;
  assign periph.id   = MID;

  assign job_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign job_id_o    = job_id_q;
  assign err_o       = err_q;

endmodule
